// File: rtl/lsq_mem_sched.sv
// lsq_mem_sched
// Memory-side scheduler for the load/store queue head. Issues one ready head
// entry at a time to the data-memory port (req/gnt/done), pops and commits it
// on completion, swallows responses of flushed operations and flags memory
// operations that exceed MAX_WAIT cycles after the grant.
//
// Ports:
//   clock, reset                      clock / asynchronous active-high reset
//   lsq_empty, lsq_head_instr,
//   lsq_head_ready                    queue head status
//   lsq_pop                           one-cycle pop pulse to the queue
//   flushing_instr, instr_to_flush    flush strobe and flushed tag
//   mem_req, mem_we, mem_tag          memory request, write enable, tag in flight
//   mem_gnt, mem_done                 memory grant / completion
//   commit_valid, commit_tag          one-cycle retire pulse and its tag
//   timeout_err                       sticky MAX_WAIT overrun flag
//   busy                              scheduler is not idle
module lsq_mem_sched #(
    parameter int TAG_W     = 32,
    parameter int STORE_BIT = 31,
    parameter int MAX_WAIT  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lsq_empty,
    input  logic [TAG_W-1:0] lsq_head_instr,
    input  logic             lsq_head_ready,
    output logic             lsq_pop,
    input  logic             flushing_instr,
    input  logic [TAG_W-1:0] instr_to_flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [TAG_W-1:0] mem_tag,
    input  logic             mem_gnt,
    input  logic             mem_done,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic             timeout_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, POP, DISCARD} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    // The response arrived together with the flush that sent us to DISCARD,
    // so there is nothing left to swallow.
    logic             resp_seen_reg;

    logic flush_hit;
    logic head_flushed;
    logic expired;

    always_comb begin
        flush_hit     = flushing_instr && (instr_to_flush == mem_tag);
        head_flushed  = flushing_instr && (instr_to_flush == lsq_head_instr);
        // Saturating increment: the counter never wraps.
        wait_cnt_next = (wait_cnt_reg == CNT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        expired       = (wait_cnt_next == CNT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            resp_seen_reg <= 1'b0;
            lsq_pop       <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_tag       <= '0;
            commit_valid  <= 1'b0;
            commit_tag    <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Pop/commit are single-cycle pulses, raised only on entry to POP.
            lsq_pop      <= 1'b0;
            commit_valid <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (!lsq_empty && lsq_head_ready && !head_flushed) begin
                        mem_tag   <= lsq_head_instr;
                        mem_we    <= lsq_head_instr[STORE_BIT];
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= REQ;
                    end
                end

                REQ: begin
                    if (mem_gnt) begin
                        // A flush in the grant cycle is too late: the access
                        // is already accepted, so its response must be drained.
                        mem_req       <= 1'b0;
                        wait_cnt_reg  <= '0;
                        resp_seen_reg <= 1'b0;
                        state_reg     <= flush_hit ? DISCARD : WAIT;
                    end else if (flush_hit) begin
                        // The queue drops the entry itself; no pop here.
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                WAIT: begin
                    wait_cnt_reg <= wait_cnt_next;
                    if (flush_hit) begin
                        resp_seen_reg <= mem_done;
                        state_reg     <= DISCARD;
                    end else if (mem_done || expired) begin
                        if (!mem_done) begin
                            timeout_err <= 1'b1;
                        end
                        lsq_pop      <= 1'b1;
                        commit_valid <= 1'b1;
                        commit_tag   <= mem_tag;
                        state_reg    <= POP;
                    end
                end

                POP: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                DISCARD: begin
                    wait_cnt_reg <= wait_cnt_next;
                    if (resp_seen_reg || mem_done) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    mem_req   <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_mem_sched.sv
// Directed testbench for lsq_mem_sched. Issued tags are pushed into a
// scoreboard queue; a monitor pops and compares them on every commit pulse.
module tb_lsq_mem_sched;

    localparam int MAX_WAIT = 15;

    logic        clock;
    logic        reset;
    logic        lsq_empty;
    logic [31:0] lsq_head_instr;
    logic        lsq_head_ready;
    logic        lsq_pop;
    logic        flushing_instr;
    logic [31:0] instr_to_flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_tag;
    logic        mem_gnt;
    logic        mem_done;
    logic        commit_valid;
    logic [31:0] commit_tag;
    logic        timeout_err;
    logic        busy;

    int n_cmp  = 0;
    int n_mism = 0;
    int req_cnt = 0;
    int pop_cnt = 0;
    logic [31:0] sb[$];

    lsq_mem_sched #(.TAG_W(32), .STORE_BIT(31), .MAX_WAIT(MAX_WAIT)) dut (
        .clock          (clock),
        .reset          (reset),
        .lsq_empty      (lsq_empty),
        .lsq_head_instr (lsq_head_instr),
        .lsq_head_ready (lsq_head_ready),
        .lsq_pop        (lsq_pop),
        .flushing_instr (flushing_instr),
        .instr_to_flush (instr_to_flush),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_tag        (mem_tag),
        .mem_gnt        (mem_gnt),
        .mem_done       (mem_done),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Presents a ready head, waits one cycle and checks the issued request.
    task automatic issue(input string name, input logic [31:0] tag);
        lsq_empty      = 1'b0;
        lsq_head_instr = tag;
        lsq_head_ready = 1'b1;
        tick();
        chk({name, "_req"}, 32'(mem_req), 32'd1);
        chk({name, "_tag"}, mem_tag, tag);
        chk({name, "_we"}, 32'(mem_we), 32'(tag[31]));
        lsq_head_ready = 1'b0;
    endtask

    // Scoreboard consumer: one line per retired operation.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_req) req_cnt++;
            if (lsq_pop) pop_cnt++;
            if (commit_valid) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_mism++;
                    $error("FAIL unexpected_commit: observed tag=%h expected no commit", commit_tag);
                end
                if (sb.size() != 0) begin
                    logic [31:0] exp_tag;
                    exp_tag = sb.pop_front();
                    chk("commit_tag", commit_tag, exp_tag);
                end
                chk("pop_with_commit", 32'(lsq_pop), 32'd1);
                $display("commit tag=%h at %0t", commit_tag, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_base;
        int pop_base;
        int k;
        bit found;

        reset = 1'b1; lsq_empty = 1'b1; lsq_head_instr = '0; lsq_head_ready = 1'b0;
        flushing_instr = 1'b0; instr_to_flush = '0; mem_gnt = 1'b0; mem_done = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pop", 32'(lsq_pop), 0);
        chk("rst_tag", mem_tag, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        reset = 1'b0;
        tick();

        // Load, grant in first REQ cycle, done two cycles after grant.
        req_base = req_cnt; pop_base = pop_cnt;
        issue("t1", 32'h0000_0005);
        sb.push_back(32'h0000_0005);
        mem_gnt = 1'b1;
        tick(); chk("t1_req_drop", 32'(mem_req), 0); mem_gnt = 1'b0;
        tick(); mem_done = 1'b1;
        tick(); chk("t1_pop", 32'(lsq_pop), 1); mem_done = 1'b0; lsq_empty = 1'b1;
        tick(); chk("t1_pop_pulse", 32'(lsq_pop), 0); chk("t1_idle", 32'(busy), 0);
        chk("t1_req_cycles", 32'(req_cnt - req_base), 1);
        chk("t1_pops", 32'(pop_cnt - pop_base), 1);
        $display("t1 load done");

        // Store with grant backpressure for three cycles.
        req_base = req_cnt; pop_base = pop_cnt;
        issue("t2", 32'h8000_0007);
        sb.push_back(32'h8000_0007);
        tick(); tick();
        tick(); chk("t2_req_held", 32'(mem_req), 1); mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0; mem_done = 1'b1;
        tick(); chk("t2_pop", 32'(lsq_pop), 1); mem_done = 1'b0; lsq_empty = 1'b1;
        tick(); chk("t2_idle", 32'(busy), 0);
        chk("t2_req_cycles", 32'(req_cnt - req_base), 4);
        chk("t2_pops", 32'(pop_cnt - pop_base), 1);
        $display("t2 store done");

        // Flush hitting the request before grant.
        pop_base = pop_cnt;
        issue("t3a", 32'h0000_0009);
        flushing_instr = 1'b1; instr_to_flush = 32'h0000_0009;
        tick(); chk("t3a_req_drop", 32'(mem_req), 0); chk("t3a_idle", 32'(busy), 0);
        flushing_instr = 1'b0; lsq_empty = 1'b1;
        tick(); tick();
        chk("t3a_no_pop", 32'(pop_cnt - pop_base), 0);
        $display("t3a flush-before-grant done");

        // Flush of an unrelated tag leaves the operation untouched.
        pop_base = pop_cnt;
        issue("t3b", 32'h0000_0009);
        flushing_instr = 1'b1; instr_to_flush = 32'h0000_0004;
        tick(); chk("t3b_req_kept", 32'(mem_req), 1);
        flushing_instr = 1'b0; mem_gnt = 1'b1; sb.push_back(32'h0000_0009);
        tick(); mem_gnt = 1'b0; mem_done = 1'b1;
        tick(); chk("t3b_pop", 32'(lsq_pop), 1); mem_done = 1'b0; lsq_empty = 1'b1;
        tick(); chk("t3b_pops", 32'(pop_cnt - pop_base), 1);
        $display("t3b flush-miss done");

        // Flush after grant in the same cycle as mem_done.
        pop_base = pop_cnt;
        issue("t4", 32'h0000_000C);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0; flushing_instr = 1'b1; instr_to_flush = 32'h0000_000C; mem_done = 1'b1;
        tick(); chk("t4_discard_busy", 32'(busy), 1);
        flushing_instr = 1'b0; mem_done = 1'b0; lsq_empty = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        chk("t4_idle", 32'(busy), 0);
        chk("t4_no_pop", 32'(pop_cnt - pop_base), 0);
        chk("t4_no_timeout", 32'(timeout_err), 0);
        $display("t4 flush-with-done done");

        // Timeout: mem_done never arrives.
        pop_base = pop_cnt;
        issue("t5", 32'h0000_0033);
        mem_gnt = 1'b1; sb.push_back(32'h0000_0033);
        k = 0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(); mem_gnt = 1'b0; k++;
            if (timeout_err) begin found = 1'b1; break; end
        end
        chk("t5_timeout_seen", 32'(found), 1);
        // Counter clears on the grant edge and expires MAX_WAIT edges later.
        chk("t5_timeout_latency", 32'(k), 32'(MAX_WAIT + 1));
        chk("t5_pop", 32'(lsq_pop), 1);
        lsq_empty = 1'b1;
        tick(); chk("t5_pops", 32'(pop_cnt - pop_base), 1);
        issue("t5b", 32'h0000_0021);
        mem_gnt = 1'b1; sb.push_back(32'h0000_0021);
        tick(); mem_gnt = 1'b0; mem_done = 1'b1;
        tick(); chk("t5b_pop", 32'(lsq_pop), 1); mem_done = 1'b0; lsq_empty = 1'b1;
        chk("t5b_sticky", 32'(timeout_err), 1);
        tick();
        $display("t5 timeout done");

        // Reset mid-WAIT, then back-to-back heads 1 and 2.
        issue("t6", 32'h0000_0044);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_req", 32'(mem_req), 0);
        chk("t6_rst_timeout", 32'(timeout_err), 0);
        chk("t6_rst_tag", mem_tag, 0);
        chk("t6_rst_commit", 32'(commit_valid), 0);
        lsq_empty = 1'b1;
        tick(); tick(); reset = 1'b0;
        tick();
        pop_base = pop_cnt;
        issue("t6_h1", 32'h0000_0001);
        mem_gnt = 1'b1; sb.push_back(32'h0000_0001);
        tick(); mem_gnt = 1'b0; mem_done = 1'b1;
        tick(); chk("t6_pop1", 32'(lsq_pop), 1); mem_done = 1'b0;
        lsq_head_instr = 32'h0000_0002; lsq_head_ready = 1'b1;
        tick(); chk("t6_gap", 32'(mem_req), 0);
        tick(); chk("t6_req2", 32'(mem_req), 1); chk("t6_tag2", mem_tag, 32'h0000_0002);
        lsq_head_ready = 1'b0; mem_gnt = 1'b1; sb.push_back(32'h0000_0002);
        tick(); mem_gnt = 1'b0; mem_done = 1'b1;
        tick(); chk("t6_pop2", 32'(lsq_pop), 1); mem_done = 1'b0; lsq_empty = 1'b1;
        tick(); tick();
        chk("t6_pops", 32'(pop_cnt - pop_base), 2);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("t6 reset and back-to-back done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
